match_run_monitor: RTL

- Consumes the 1-bit registered Moore output `z` of the two-equal-bits sequence detector. Runs on the same clock and samples `z` every cycle.
- Counts detection episodes (rising edges of `z`) and measures the current and longest run of consecutive high `z` cycles.
- Raises a registered alarm once a run reaches a programmable length.
- Results feed the experiment board's LED/7-segment display logic.

---
 rtl/match_run_monitor_if.sv | 46 ++++
 rtl/match_run_monitor.sv | 130 +++++++++++++
 2 files changed

// File: rtl/match_run_monitor_if.sv
// -----------------------------------------------------------------------------
// match_run_monitor_if
// Bundles the sampled detector signal, the synchronous clear and the monitor
// results into one interface.
//
// Signals:
//   z          detector output, sampled by the monitor each rising clk edge
//   clr        synchronous clear, active-high
//   hit_count  number of z rising edges since reset/clr (saturating)
//   run_len    length of the current high run of z (saturating)
//   max_run    largest run_len reached since reset/clr
//   rise       one-cycle pulse: last sample started a new run
//   alarm      high while the current run length >= ALARM_LEN
//   state_dbg  current FSM state (0=IDLE, 1=RUN, 2=ALARM)
//
// Handshake: there is no valid/ready pair. The source holds z and clr stable
// around every rising clk edge; the monitor treats each edge as one accepted
// sample, and all results are valid from just after that edge until the next.
//
// Modports:
//   master  drives z/clr, observes results (source / bench side)
//   slave   consumes z/clr, drives results (monitor side)
// -----------------------------------------------------------------------------
interface match_run_monitor_if #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 6
);
  logic             z;
  logic             clr;
  logic [CNT_W-1:0] hit_count;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] max_run;
  logic             rise;
  logic             alarm;
  logic [1:0]       state_dbg;

  modport master (
    output z, clr,
    input  hit_count, run_len, max_run, rise, alarm, state_dbg
  );

  modport slave (
    input  z, clr,
    output hit_count, run_len, max_run, rise, alarm, state_dbg
  );
endinterface

// File: rtl/match_run_monitor.sv
// -----------------------------------------------------------------------------
// match_run_monitor
// Watches the registered output z of a two-equal-bits sequence detector.
// Counts detection episodes (rising edges of z), tracks the current and the
// longest run of consecutive high samples, and raises a registered alarm once
// the current run reaches ALARM_LEN. All outputs are registered.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous reset, active-low
//   bus    match_run_monitor_if.slave (z, clr in; results + state_dbg out)
//
// Parameters:
//   CNT_W      width of hit_count
//   RUN_W      width of run_len / max_run
//   ALARM_LEN  run length that asserts alarm, 1 .. 2^RUN_W-1
// -----------------------------------------------------------------------------
module match_run_monitor #(
  parameter int CNT_W     = 8,
  parameter int RUN_W     = 6,
  parameter int ALARM_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  match_run_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [RUN_W-1:0] ALARM_LEN_V = RUN_W'(ALARM_LEN);

  state_t           r_state;
  logic [CNT_W-1:0] r_hit;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] r_max;
  logic             r_rise;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_hit_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [RUN_W-1:0] w_max_nxt;
  logic             w_rise_nxt;
  logic [RUN_W-1:0] w_run_inc;
  logic [CNT_W-1:0] w_hit_inc;

  // Saturating increments: all-ones values stick.
  assign w_run_inc = (r_run == '1) ? r_run : r_run + 1'b1;
  assign w_hit_inc = (r_hit == '1) ? r_hit : r_hit + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = r_hit;
    w_run_nxt   = r_run;
    w_max_nxt   = r_max;
    w_rise_nxt  = 1'b0;

    if (bus.clr) begin
      // z is ignored this cycle; a still-high z on the next edge is a new hit.
      w_state_nxt = IDLE;
      w_hit_nxt   = '0;
      w_run_nxt   = '0;
      w_max_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.z) begin
            w_run_nxt   = RUN_W'(1);
            w_rise_nxt  = 1'b1;
            w_hit_nxt   = w_hit_inc;
            w_state_nxt = (ALARM_LEN == 1) ? ALARM : RUN;
          end else begin
            w_run_nxt   = '0;
          end
        end
        RUN: begin
          if (bus.z) begin
            w_run_nxt   = w_run_inc;
            w_state_nxt = (w_run_inc == ALARM_LEN_V) ? ALARM : RUN;
          end else begin
            w_run_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
        ALARM: begin
          if (bus.z) begin
            w_run_nxt   = w_run_inc;
          end else begin
            w_run_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_run_nxt   = '0;
          w_state_nxt = IDLE;
        end
      endcase
      // max_run tracks the run length being registered at this same edge.
      if (w_run_nxt > r_max) w_max_nxt = w_run_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hit   <= '0;
      r_run   <= '0;
      r_max   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hit   <= w_hit_nxt;
      r_run   <= w_run_nxt;
      r_max   <= w_max_nxt;
      r_rise  <= w_rise_nxt;
    end
  end

  assign bus.hit_count = r_hit;
  assign bus.run_len   = r_run;
  assign bus.max_run   = r_max;
  assign bus.rise      = r_rise;
  // Decoded from the state register only, so it stays aligned with run_len.
  assign bus.alarm     = (r_state == ALARM);
  assign bus.state_dbg = r_state;

endmodule
